apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the width of the paddr/req_addr buses.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of the pdata/prdata/req_wdata/rsp_rdata buses.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the max ACCESS cycles without pready before abort.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-005 pclk  in  1  APB clock; all state changes on the rising edge.
REQ-006 presetn  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  CPU request present.
REQ-008 req_ready  out  1  request accepted this cycle when req_valid=1.
REQ-009 req_addr  in  ADDR_WIDTH  request address.
REQ-010 req_wdata  in  DATA_WIDTH  write data.
REQ-011 req_write  in  1  1=write, 0=read.
REQ-012 req_strb  in  4  write byte strobes.
REQ-013 rsp_valid  out  1  one-cycle response pulse.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors).
REQ-015 rsp_err  out  1  perr seen or timeout.
REQ-016 rsp_timeout  out  1  timeout abort; qualifies rsp_err.
REQ-017 paddr, pdata, pwrite, pstb[3:0], psel, penable  out  APB request signals to the decoder.
REQ-018 prdata  in  DATA_WIDTH;  pready  in  1;  perr  in  1  APB completion from the decoder.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP, all encoded in apb_pkg.
REQ-020 req_ready SHALL be 1 only in IDLE; req_valid&req_ready SHALL latch addr/wdata/write/strb and move to SETUP.
REQ-021 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then move to ACCESS.
REQ-022 ACCESS SHALL drive psel=1, penable=1 until pready=1 or timeout.
REQ-023 paddr/pwrite/pdata/pstb SHALL hold stable from SETUP through the last ACCESS cycle.
REQ-024 pstb SHALL be 4'b0000 on reads; pdata SHALL be 0 on reads.
REQ-025 When pready=1 in ACCESS, the block SHALL capture prdata (reads only, else 0) and perr into rsp_rdata/rsp_err, set rsp_timeout=0 and move to RESP.
REQ-026 RESP SHALL assert rsp_valid for exactly one cycle with psel=penable=0, then return to IDLE.
REQ-027 Minimum latency SHALL be: accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3.
REQ-028 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-029 When the counter equals TIMEOUT with pready=0, the block SHALL abort to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-030 pready=1 on the same cycle the counter reaches TIMEOUT SHALL complete normally (pready wins).
REQ-031 pready/perr/prdata SHALL be ignored outside ACCESS.
REQ-032 The response SHALL have no backpressure; rsp_* SHALL hold their values until the next RESP, and rsp_valid alone qualifies them.
REQ-033 The counter width SHALL be $clog2(TIMEOUT+1) bits and SHALL not wrap.

Reset
REQ-034 presetn=0 SHALL immediately force IDLE, psel=0, penable=0, rsp_valid=0 and clear the counter.
REQ-035 Reset values SHALL be: paddr=0, pdata=0, pwrite=0, pstb=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0; req_ready=1 once in IDLE.
REQ-036 Reset mid-transaction SHALL drop the transfer and produce no rsp_valid.

Structure
REQ-037 apb_pkg SHALL hold the state enum typedef and the APB_TIMEOUT_DEFAULT=255 constant.
REQ-038 The wait counter SHALL be the sub-module apb_watchdog (inputs clear and count, output expired).

Verification
REQ-039 Read 0x80000010, pready=1 in the first ACCESS, prdata=0xDEADBEEF -> rsp_valid at N+3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-040 Write 0x10000000, data=0x41, strb=4'b0001, pready delayed 3 cycles -> psel held for 5 cycles, penable for 4, paddr/pdata stable throughout, rsp_err=0.
REQ-041 Read 0x00050000 with decoder perr=1, pready=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-042 TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles with rsp_err=1, rsp_timeout=1, psel=0 in RESP.
REQ-043 presetn pulsed low during ACCESS -> psel=0 asynchronously, no rsp_valid, req_ready=1 after release.
REQ-044 Back-to-back requests with req_valid held 1 -> second accept occurs the cycle after RESP, 4-cycle issue spacing.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master: FSM state encoding and the
// default ACCESS-phase wait limit.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int APB_TIMEOUT_DEFAULT = 255;

    // Width of a counter able to hold 0..limit; never narrower than one bit.
    function automatic int wait_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase wait counter: cleared on entry to ACCESS, counts stalled cycles
// and saturates at TIMEOUT, where it flags expiry.
module apb_watchdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CNT_W = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == LIMIT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; a blocking '=' here would race with readers of cnt.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one CPU request, runs SETUP/ACCESS
// on the bus, and returns a one-cycle response pulse with data/error/timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = APB_TIMEOUT_DEFAULT
) (
    input  logic                  pclk,
    input  logic                  presetn,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_write,
    input  logic [3:0]            req_strb,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);

    apb_state_e state;
    logic       wd_clear;
    logic       wd_count;
    logic       wd_expired;

    // SETUP always precedes ACCESS, so clearing there gives a fresh count on entry.
    assign wd_clear = (state == ST_SETUP);
    assign wd_count = (state == ST_ACCESS) && !pready;

    apb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (wd_clear),
        .count   (wd_count),
        .expired (wd_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= ST_IDLE;
            // NOTE: req_ready is a registered copy of (state == IDLE), so its
            // reset value must be 1 to match the reset state.
            req_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pdata       <= '0;
            pwrite      <= 1'b0;
            pstb        <= 4'b0000;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        paddr     <= req_addr;
                        pwrite    <= req_write;
                        pdata     <= req_write ? req_wdata : '0;
                        pstb      <= req_write ? req_strb : 4'b0000;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // pready is checked first so a completion on the expiry cycle wins.
                    if (pready) begin
                        rsp_rdata   <= (pwrite || perr) ? '0 : prdata;
                        rsp_err     <= perr;
                        rsp_timeout <= 1'b0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (wd_expired) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
